// File: rtl/i2s_pkg.sv
// i2s_pkg: shared channel encoding and default widths for the I2S target.
package i2s_pkg;
  localparam int I2S_DATA_W = 24;
  localparam int I2S_CNT_W  = 6;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} ch_e;
  function automatic logic [1:0] ch_onehot(input ch_e c);
    return (c == CH_RIGHT) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/i2s_target_if_if.sv
// i2s_target_if_if: sample-side handshake bundle; slave = I2S target, master = sample consumer/producer.
interface i2s_target_if_if #(parameter int DATA_W = 24);
  logic [1:0]        rx_vld;
  logic [DATA_W-1:0] rx_data;
  logic [1:0]        tx_ack;
  logic [DATA_W-1:0] tx_data0;
  logic [DATA_W-1:0] tx_data1;
  logic              frame_err;
  modport master(input rx_vld, rx_data, tx_ack, frame_err, output tx_data0, tx_data1);
  modport slave(output rx_vld, rx_data, tx_ack, frame_err, input tx_data0, tx_data1);
endinterface

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: 2-FF synchroniser with one-clk rise/fall strobes from a third history stage.
module i2s_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= {sh_q[1:0], d_i};
  end
  assign q_o    = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/i2s_target_if.sv
// i2s_target_if: codec-side I2S target; deserialises SDIN and serialises SDOUT, 24-bit MSB-first.
// Define I2S_TARGET_FRAMECHK_EN to build the sticky short-frame detector on frame_err.
module i2s_target_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int CNT_W  = I2S_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i2s_sclk,
  input  logic i2s_lrclk,
  input  logic i2s_sdin,
  output logic i2s_sdout,
  i2s_target_if_if.slave dp
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);
  logic sck_r, sck_f, lr_s, sd_s;
  logic [4:0] sync_unused;
  i2s_sync_edge u_sclk (.clk(clk), .rst(rst), .d_i(i2s_sclk), .q_o(sync_unused[0]),
                        .rise_o(sck_r), .fall_o(sck_f));
  i2s_sync_edge u_lrclk (.clk(clk), .rst(rst), .d_i(i2s_lrclk), .q_o(lr_s),
                         .rise_o(sync_unused[1]), .fall_o(sync_unused[2]));
  i2s_sync_edge u_sdin (.clk(clk), .rst(rst), .d_i(i2s_sdin), .q_o(sd_s),
                        .rise_o(sync_unused[3]), .fall_o(sync_unused[4]));
  logic              lr_prev_q, lr_prev_d, lr_seen_q, lr_seen_d, armed_q, armed_d;
  ch_e               cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_W-2:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d, tx_sh_q, tx_sh_d, rx_next;
  logic [1:0]        rx_vld_q, rx_vld_d, tx_ack_q, tx_ack_d;
  logic              sdout_q, sdout_d;
  logic              boundary, capture, last;
  // lr_seen gates boundary detection so the first sampled LRCLK level after reset is not an edge
  assign boundary = sck_r & lr_seen_q & (lr_s != lr_prev_q);
  assign capture  = sck_r & ~boundary & armed_q & (bitcnt_q < FULL);
  assign last     = capture & (bitcnt_q == FULL - 1'b1);
  assign rx_next  = {rx_sh_q, sd_s};
  always_comb begin
    lr_prev_d = sck_r ? lr_s : lr_prev_q;
    lr_seen_d = lr_seen_q | sck_r;
    armed_d   = armed_q | boundary;
    cur_ch_d  = boundary ? ch_e'(lr_s) : cur_ch_q;
    bitcnt_d  = boundary ? '0 : capture ? bitcnt_q + 1'b1 : bitcnt_q;
    rx_sh_d   = boundary ? '0 : capture ? rx_next[DATA_W-2:0] : rx_sh_q;
    rx_vld_d  = last ? ch_onehot(cur_ch_q) : 2'b00;
    rx_data_d = last ? rx_next : rx_data_q;
    tx_ack_d  = boundary ? ch_onehot(ch_e'(lr_s)) : 2'b00;
    tx_sh_d   = boundary ? (lr_s ? dp.tx_data1 : dp.tx_data0) : sck_f ? tx_sh_q << 1 : tx_sh_q;
    sdout_d   = sck_f ? tx_sh_q[DATA_W-1] : sdout_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_prev_q <= 1'b0;
      lr_seen_q <= 1'b0;
      armed_q   <= 1'b0;
      cur_ch_q  <= CH_LEFT;
      bitcnt_q  <= '0;
      rx_sh_q   <= '0;
      rx_vld_q  <= '0;
      rx_data_q <= '0;
      tx_ack_q  <= '0;
      tx_sh_q   <= '0;
      sdout_q   <= 1'b0;
    end else begin
      lr_prev_q <= lr_prev_d;
      lr_seen_q <= lr_seen_d;
      armed_q   <= armed_d;
      cur_ch_q  <= cur_ch_d;
      bitcnt_q  <= bitcnt_d;
      rx_sh_q   <= rx_sh_d;
      rx_vld_q  <= rx_vld_d;
      rx_data_q <= rx_data_d;
      tx_ack_q  <= tx_ack_d;
      tx_sh_q   <= tx_sh_d;
      sdout_q   <= sdout_d;
    end
  end
`ifdef I2S_TARGET_FRAMECHK_EN
  logic ferr_q, ferr_d;
  assign ferr_d = ferr_q | (boundary & armed_q & (bitcnt_q < FULL));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ferr_q <= 1'b0;
    else     ferr_q <= ferr_d;
  end
  assign dp.frame_err = ferr_q;
`else
  assign dp.frame_err = 1'b0;
`endif
  assign i2s_sdout  = sdout_q;
  assign dp.rx_vld  = rx_vld_q;
  assign dp.rx_data = rx_data_q;
  assign dp.tx_ack  = tx_ack_q;
endmodule

// File: tb/tb_i2s_target_if.sv
// tb_i2s_target_if: I2S master model (SCLK = clk/8) driving the target, with an rx/ack monitor.
module tb_i2s_target_if;
`ifdef I2S_TARGET_FRAMECHK_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, i2s_sclk = 1'b1, i2s_lrclk = 1'b1, i2s_sdin = 1'b0;
  logic i2s_sdout;
  int n_vec = 0, n_err = 0, ack0 = 0, ack1 = 0;
  logic [24:0] rxq[$];
  logic [24:0] expq[$];
  i2s_target_if_if #(.DATA_W(24)) dp();
  i2s_target_if dut (.clk(clk), .rst(rst), .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk),
                     .i2s_sdin(i2s_sdin), .i2s_sdout(i2s_sdout), .dp(dp));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (dp.rx_vld[0]) rxq.push_back({1'b0, dp.rx_data});
    if (dp.rx_vld[1]) rxq.push_back({1'b1, dp.rx_data});
    if (dp.tx_ack[0]) ack0++;
    if (dp.tx_ack[1]) ack1++;
  end
  task automatic do_reset();
    i2s_sclk = 1'b1; i2s_lrclk = 1'b1; i2s_sdin = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  // One half-frame as the master sees it: LRCLK changes at fall 0, data delayed one SCLK.
  task automatic run_slot(input bit ch, input logic [23:0] w, input int len, input bit exp_v,
                          output logic [23:0] got, output int pad_bad);
    got = '0; pad_bad = 0;
    for (int k = 0; k < len; k++) begin
      logic so;
      i2s_sclk = 1'b0; i2s_lrclk = ch; i2s_sdin = (k >= 1 && k <= 24) ? w[24-k] : 1'b0;
      repeat (4) @(negedge clk);
      so = i2s_sdout;
      if (k >= 1 && k <= 24) got[24-k] = so;
      else if (k > 24 && so !== 1'b0) pad_bad++;
      i2s_sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    if (exp_v) expq.push_back({ch, w});
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({dp.rx_vld, dp.tx_ack, dp.rx_data, dp.frame_err, i2s_sdout} !== 31'd0) begin
      n_err++; $display("FAIL reset_in got %h exp 0", {dp.rx_vld, dp.tx_ack, dp.rx_data, dp.frame_err, i2s_sdout});
    end
    do_reset();
    n_vec++;
    if ({dp.rx_vld, dp.tx_ack, dp.rx_data, dp.frame_err, i2s_sdout} !== 31'd0) begin
      n_err++; $display("FAIL reset_out got %h exp 0", {dp.rx_vld, dp.tx_ack, dp.rx_data, dp.frame_err, i2s_sdout});
    end
  endtask
  task automatic test_rx();
    logic [23:0] g, l, r;
    int pb, base;
    do_reset(); expq.delete(); base = rxq.size();
    run_slot(1'b1, 24'h0, 2, 1'b0, g, pb);
    for (int f = 0; f < 5; f++) begin
      l = (f == 0) ? 24'hA5A5A5 : 24'($urandom);
      r = (f == 0) ? 24'h3C3C3C : 24'($urandom);
      run_slot(1'b0, l, (f == 0) ? 32 : int'($urandom_range(25, 40)), 1'b1, g, pb);
      run_slot(1'b1, r, (f == 0) ? 32 : int'($urandom_range(25, 40)), 1'b1, g, pb);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < expq.size(); i++) begin
      n_vec++;
      if (rxq.size() <= base + i || rxq[base+i] !== expq[i]) begin
        n_err++; $display("FAIL rx[%0d] got %h exp %h", i, (rxq.size() > base + i) ? rxq[base+i] : 25'h0, expq[i]);
      end
    end
    n_vec++;
    if (rxq.size() - base != expq.size()) begin
      n_err++; $display("FAIL rx_count got %0d exp %0d", rxq.size() - base, expq.size());
    end
    n_vec++;
    if (dp.frame_err !== 1'b0) begin n_err++; $display("FAIL rx_ferr got %b exp 0", dp.frame_err); end
  endtask
  task automatic test_tx();
    logic [23:0] g;
    int pb, a0, a1;
    dp.tx_data0 = 24'h800001; dp.tx_data1 = 24'h7FFFFE;
    do_reset(); expq.delete(); a0 = ack0; a1 = ack1;
    run_slot(1'b1, 24'h0, 2, 1'b0, g, pb);
    for (int f = 0; f < 3; f++) begin
      run_slot(1'b0, 24'($urandom), 32, 1'b1, g, pb);
      n_vec++;
      if (g !== 24'h800001 || pb != 0) begin n_err++; $display("FAIL tx_l%0d got %h pad %0d exp 800001", f, g, pb); end
      run_slot(1'b1, 24'($urandom), 32, 1'b1, g, pb);
      n_vec++;
      if (g !== 24'h7FFFFE || pb != 0) begin n_err++; $display("FAIL tx_r%0d got %h pad %0d exp 7ffffe", f, g, pb); end
    end
    n_vec++;
    if (ack0 - a0 != 3 || ack1 - a1 != 3) begin
      n_err++; $display("FAIL tx_ack got %0d/%0d exp 3/3", ack0 - a0, ack1 - a1);
    end
  endtask
  task automatic test_loopback();
    logic [23:0] txl[16], txr[16];
    logic [23:0] pl, pr, g;
    int pb, base;
    logic [23:0] b;
    b = 24'($urandom);
    for (int f = 0; f < 16; f++) begin txl[f] = b + 24'(f); txr[f] = b + 24'(f) + 24'h100000; end
    do_reset(); expq.delete(); base = rxq.size(); pl = '0; pr = '0;
    run_slot(1'b1, 24'h0, 2, 1'b0, g, pb);
    for (int f = 0; f < 16; f++) begin
      dp.tx_data0 = txl[f]; dp.tx_data1 = txr[f];
      run_slot(1'b0, pl, 32, 1'b1, g, pb);
      pl = g;
      n_vec++;
      if (g !== txl[f]) begin n_err++; $display("FAIL loop_tx_l%0d got %h exp %h", f, g, txl[f]); end
      run_slot(1'b1, pr, 32, 1'b1, g, pb);
      pr = g;
      n_vec++;
      if (g !== txr[f]) begin n_err++; $display("FAIL loop_tx_r%0d got %h exp %h", f, g, txr[f]); end
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      logic [24:0] e;
      e = (i < 2) ? {i[0], 24'h0} : {i[0], i[0] ? txr[i/2-1] : txl[i/2-1]};
      n_vec++;
      if (rxq.size() <= base + i || rxq[base+i] !== e) begin
        n_err++; $display("FAIL loop_rx[%0d] got %h exp %h", i, (rxq.size() > base + i) ? rxq[base+i] : 25'h0, e);
      end
    end
    n_vec++;
    if (rxq.size() - base != 32) begin n_err++; $display("FAIL loop_count got %0d exp 32", rxq.size() - base); end
  endtask
  task automatic test_short_frame();
    logic [23:0] g, l, r;
    int pb, base;
    do_reset(); expq.delete(); base = rxq.size();
    run_slot(1'b1, 24'h0, 2, 1'b0, g, pb);
    run_slot(1'b0, 24'($urandom), 32, 1'b1, g, pb);
    n_vec++;
    if (dp.frame_err !== 1'b0) begin n_err++; $display("FAIL short_pre_ferr got %b exp 0", dp.frame_err); end
    run_slot(1'b1, 24'($urandom), 20, 1'b0, g, pb);
    l = 24'($urandom); r = 24'($urandom);
    run_slot(1'b0, l, 32, 1'b1, g, pb);
    n_vec++;
    if (dp.frame_err !== FE) begin n_err++; $display("FAIL short_ferr got %b exp %b", dp.frame_err, FE); end
    run_slot(1'b1, r, 32, 1'b1, g, pb);
    repeat (8) @(negedge clk);
    for (int i = 0; i < expq.size(); i++) begin
      n_vec++;
      if (rxq.size() <= base + i || rxq[base+i] !== expq[i]) begin
        n_err++; $display("FAIL short_rx[%0d] got %h exp %h", i, (rxq.size() > base + i) ? rxq[base+i] : 25'h0, expq[i]);
      end
    end
    n_vec++;
    if (rxq.size() - base != 3) begin n_err++; $display("FAIL short_count got %0d exp 3", rxq.size() - base); end
    n_vec++;
    if (dp.frame_err !== FE) begin n_err++; $display("FAIL short_sticky got %b exp %b", dp.frame_err, FE); end
  endtask
  task automatic test_reset_mid();
    logic [23:0] g;
    int pb, base;
    do_reset(); expq.delete();
    run_slot(1'b1, 24'h0, 2, 1'b0, g, pb);
    run_slot(1'b0, 24'($urandom), 32, 1'b0, g, pb);
    run_slot(1'b1, 24'($urandom), 32, 1'b0, g, pb);
    run_slot(1'b0, 24'($urandom), 10, 1'b0, g, pb);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({dp.rx_vld, dp.tx_ack, dp.rx_data, dp.frame_err, i2s_sdout} !== 31'd0) begin
        n_err++; $display("FAIL mid_rst%0d got %h exp 0", i, {dp.rx_vld, dp.tx_ack, dp.rx_data, dp.frame_err, i2s_sdout});
      end
    end
    rst = 1'b0;
    base = rxq.size();
    run_slot(1'b0, 24'($urandom), 22, 1'b0, g, pb);
    n_vec++;
    if (rxq.size() != base || g !== 24'h0) begin
      n_err++; $display("FAIL mid_idle got vld %0d sdout %h exp 0 0", rxq.size() - base, g);
    end
    run_slot(1'b1, 24'($urandom), 32, 1'b1, g, pb);
    run_slot(1'b0, 24'($urandom), 32, 1'b1, g, pb);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (rxq.size() <= base + i || rxq[base+i] !== expq[i]) begin
        n_err++; $display("FAIL mid_rx[%0d] got %h exp %h", i, (rxq.size() > base + i) ? rxq[base+i] : 25'h0, expq[i]);
      end
    end
  endtask
  task automatic test_powerup();
    logic [23:0] g;
    int pb, base, a0, a1;
    do_reset(); expq.delete(); base = rxq.size(); a0 = ack0; a1 = ack1;
    for (int s = 0; s < 3; s++) begin
      run_slot(1'b1, 24'($urandom), 32, 1'b0, g, pb);
      n_vec++;
      if (g !== 24'h0 || pb != 0) begin n_err++; $display("FAIL pwr_sdout%0d got %h pad %0d exp 0", s, g, pb); end
    end
    n_vec++;
    if (rxq.size() != base || ack0 != a0 || ack1 != a1) begin
      n_err++; $display("FAIL pwr_quiet got vld %0d ack %0d/%0d exp 0", rxq.size() - base, ack0 - a0, ack1 - a1);
    end
    run_slot(1'b0, 24'($urandom), 32, 1'b1, g, pb);
    run_slot(1'b1, 24'($urandom), 32, 1'b1, g, pb);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (rxq.size() <= base + i || rxq[base+i] !== expq[i]) begin
        n_err++; $display("FAIL pwr_rx[%0d] got %h exp %h", i, (rxq.size() > base + i) ? rxq[base+i] : 25'h0, expq[i]);
      end
    end
  endtask
  initial begin
    dp.tx_data0 = '0; dp.tx_data1 = '0;
    test_reset();
    test_rx();
    test_tx();
    test_loopback();
    test_short_frame();
    test_reset_mid();
    test_powerup();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
